// File: rtl/sshl_pkg.sv
// Shared types and constants for the shift-left overflow output stage.
package sshl_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sshl_ovf_chk.sv
// Signed overflow check for a left shift: undoes the shift arithmetically
// and compares against the original operand.
module sshl_ovf_chk #(
   parameter int DATAWIDTH = 32
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   input  logic [DATAWIDTH-1:0] d,
   output logic                 ovf
);

   localparam logic [DATAWIDTH-1:0] LIMIT = DATAWIDTH'(DATAWIDTH);

   logic signed [DATAWIDTH-1:0] back;

   assign back = $signed(d) >>> sh_amt;

   // Shifting by the full width or more leaves only zero representable.
   always_comb begin
      ovf = 1'b0;
      if (sh_amt < LIMIT) begin
         ovf = (back != $signed(a));
      end else begin
         ovf = |a;
      end
   end

endmodule

// File: rtl/sshl_out_stage.sv
// Two-entry output FIFO for shifter results, tagging each entry with a
// signed-overflow flag and keeping a saturating overflow count.
//
// state    | meaning
// ST_EMPTY | no entries stored, out_valid low
// ST_ONE   | one entry stored, can accept and present
// ST_FULL  | two entries stored, in_ready low
module sshl_out_stage
   import sshl_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   input  logic [DATAWIDTH-1:0] d,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_d,
   output logic                 out_ovf,
   output logic [CNT_W-1:0]     ovf_cnt
);

   occ_state_t state, state_nxt;

   logic                 rdy_en;
   logic [DATAWIDTH-1:0] mem_d   [2];
   logic                 mem_ovf [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic                 push;
   logic                 pop;
   logic                 ovf;

   sshl_ovf_chk #(
      .DATAWIDTH (DATAWIDTH)
   ) u_ovf_chk (
      .a      (a),
      .sh_amt (sh_amt),
      .d      (d),
      .ovf    (ovf)
   );

   // rdy_en keeps in_ready low through reset and for the cycle it releases.
   assign in_ready  = rdy_en && (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_d     = mem_d[rd_ptr];
   assign out_ovf   = mem_ovf[rd_ptr];

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state  <= ST_EMPTY;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (push) state_nxt = ST_ONE;
         end
         ST_ONE: begin
            if (push && !pop)      state_nxt = ST_FULL;
            else if (pop && !push) state_nxt = ST_EMPTY;
         end
         ST_FULL: begin
            if (pop) state_nxt = ST_ONE;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         mem_d   <= '{default: '0};
         mem_ovf <= '{default: 1'b0};
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         ovf_cnt <= '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr]   <= d;
            mem_ovf[wr_ptr] <= ovf;
            wr_ptr          <= ~wr_ptr;
            if (ovf) ovf_cnt <= sat_inc(ovf_cnt);
         end
         if (pop) rd_ptr <= ~rd_ptr;
      end
   end

endmodule

// File: doc/sshl_out_stage.md
SSHL_OUT_STAGE -- requirements
Module: sshl_out_stage

Interface
REQ-001: Parameter DATAWIDTH, default 32, operand and result width in bits.
REQ-002: Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: Rst  input  1  reset, asynchronous, active-low.
REQ-004: in_valid  input  1  upstream result available this cycle.
REQ-005: in_ready  output  1  stage can accept an input this cycle.
REQ-006: a  input  DATAWIDTH  signed operand originally presented to the shifter.
REQ-007: sh_amt  input  DATAWIDTH  unsigned shift amount originally presented to the shifter.
REQ-008: d  input  DATAWIDTH  signed shifter result, a << sh_amt.
REQ-009: out_valid  output  1  head entry valid.
REQ-010: out_ready  input  1  downstream accepts head entry.
REQ-011: out_d  output  DATAWIDTH  head entry result.
REQ-012: out_ovf  output  1  head entry signed-overflow flag.
REQ-013: ovf_cnt  output  8  saturating count of overflowed entries accepted.

Function
REQ-014: Input transfer occurs on an edge where in_valid and in_ready are both high; output transfer occurs where out_valid and out_ready are both high.
REQ-015: Storage is a 2-entry FIFO holding {d, ovf} per entry, in order.
REQ-016: Occupancy FSM states: EMPTY, ONE, FULL.
REQ-017: Transitions: EMPTY push -> ONE; ONE push-only -> FULL; ONE pop-only -> EMPTY; ONE push+pop -> ONE; FULL pop -> ONE; all other cases hold.
REQ-018: in_ready is high in EMPTY and ONE, low in FULL; it is a registered function of state only, with no combinational path from out_ready.
REQ-019: out_valid is high in ONE and FULL; out_d/out_ovf present the oldest entry.
REQ-020: Latency: an entry accepted at edge N is presented on out_valid after edge N when the FIFO was EMPTY.
REQ-021: ovf is computed at acceptance: for sh_amt < DATAWIDTH, ovf = 1 when (d >>> sh_amt) != a (arithmetic shift); for sh_amt >= DATAWIDTH, ovf = 1 when a != 0.
REQ-022: ovf_cnt increments by 1 on each accepted entry with ovf = 1 and holds at 255.
REQ-023: In FULL, in_valid is ignored and no data is overwritten; in EMPTY, out_ready is ignored.
REQ-024: out_d, out_ovf hold their values while out_valid is high and out_ready is low.

Reset
REQ-025: When Rst is low, state becomes EMPTY immediately, with out_valid = 0, in_ready = 0, out_d = 0, out_ovf = 0, ovf_cnt = 0.
REQ-026: in_ready rises on the first edge after Rst deasserts.
REQ-027: Assertion mid-transfer discards all stored entries; no partial transfer completes.

Structure
REQ-028: Occupancy state encodings and the ovf_cnt width/saturation constant reside in shared package sshl_pkg.
REQ-029: The overflow test is a combinational sub-module sshl_ovf_chk (a, sh_amt, d -> ovf), parameterised by DATAWIDTH.

Verification
REQ-030: Reset: Rst low mid-FULL -> out_valid = 0, ovf_cnt = 0 with no clock; first edge after release -> in_ready = 1.
REQ-031: DATAWIDTH = 8, a = 8'sh03, sh_amt = 2, d = 8'sh0C, out_ready = 1 -> out_d = 8'h0C, out_ovf = 0 one edge later.
REQ-032: DATAWIDTH = 8, a = 8'sh40, sh_amt = 1, d = 8'sh80 -> out_ovf = 1, ovf_cnt = 1; a = 8'sh01, sh_amt = 9, d = 0 -> out_ovf = 1, ovf_cnt = 2.
REQ-033: Backpressure: out_ready = 0 with three back-to-back pushes (1, 2, 3) -> in_ready low after the 2nd push, 3rd held upstream; release -> outputs 1, 2, 3 in order with no loss or duplication.
REQ-034: Simultaneous push+pop in ONE for 10 cycles -> state stays ONE and the output sequence equals the input sequence.
REQ-035: 300 overflowing entries -> ovf_cnt = 255 and holds.
